arith_order_issuer: RTL and testbench
=====================================

// Module: arith_order_issuer
// PURPOSE
//   Initiator side of the order/answer handshake with the arithmetic local program sensor (arith_ctrl).
//   Accepts one decoded arithmetic opcode at a time from the op sequencer and drives exactly one order pulse.
//   Waits for the au_answer pulse, then reports completion. Flags timeouts, illegal opcodes and stray answers.
//   Sits between op decode and arith_ctrl. Owns the order_*_from_op pulses; arith_ctrl consumes them.
// PARAMETERS
//   STARTUP_CYCLES  4    cycles after reset/abort before op_ready may rise (lets arith_ctrl FSMs settle to idle)
//   TIMEOUT_CYCLES  255  max WAIT cycles without answer before timeout_err; must be >=2 and <=2**CNT_W-1
//   CNT_W           8    width of startup/wait counter
// PORTS
//   clk              in   1   clock
//   reset            in   1   asynchronous, active-high reset
//   op_valid         in   1   opcode offered (level)
//   op_code          in   3   0=add 1=sub 2=mul 3=div 4=and, 5..7 illegal
//   op_ready         out  1   issuer can accept; transfer when op_valid && op_ready at posedge
//   clear_a_from_pu  in   1   pulse, abort; also resets arith_ctrl FSMs
//   au_answer        in   1   pulse, completion from arith_ctrl
//   order_add        out  1   pulse to arith_ctrl
//   order_sub        out  1   pulse to arith_ctrl
//   order_mul        out  1   pulse to arith_ctrl
//   order_div        out  1   pulse to arith_ctrl
//   order_and        out  1   pulse to arith_ctrl
//   done             out  1   pulse, operation completed
//   busy             out  1   level, state != IDLE
//   timeout_err      out  1   pulse, no answer within TIMEOUT_CYCLES
//   illegal_err      out  1   pulse, opcode 5..7 accepted
//   spurious_err     out  1   pulse, au_answer outside WAIT
//   op_count         out  16  completed operations, wraps 0xFFFF->0
// BEHAVIOUR
//   All outputs registered. Reset: state=INIT, cnt=0, op_count=0, all pulses 0, op_ready=0, busy=1.
//   States: INIT, IDLE, ISSUE, WAIT, DONE.
//   INIT: cnt increments each cycle. At cnt==STARTUP_CYCLES-1, goes to IDLE and cnt is cleared.
//   IDLE: op_ready=1. On transfer, op_code is latched.
//     Legal opcode -> ISSUE.
//     Illegal opcode -> illegal_err pulses the next cycle; stays IDLE. op_ready drops for that cycle.
//   ISSUE: exactly one order_* pulse is high for this one cycle, decoded from the latched opcode. Next state is WAIT with cnt=0.
//     Latency: transfer at edge N -> order pulse in cycle N+1.
//   WAIT: cnt increments each cycle.
//     au_answer -> DONE.
//     Else if cnt==TIMEOUT_CYCLES-1 -> timeout_err pulse next cycle, then IDLE.
//     Answer in the limit cycle wins over timeout.
//   DONE: done pulse for one cycle, op_count+1, op_ready=1 in the same cycle. A transfer here is accepted exactly as in IDLE.
//     So back-to-back orders are separated by >=1 idle cycle on the order lines.
//   au_answer in INIT/IDLE/ISSUE/DONE -> spurious_err pulse next cycle. State is unaffected.
//   clear_a_from_pu (any state): state->INIT and cnt=0. No done/timeout is produced for the aborted op.
//     Any order pulse due next cycle is suppressed.
//     clear has priority over au_answer, timeout and transfer.
//     op_count is kept.
//   Error pulses can coincide only as spurious_err with illegal_err. Both assert.
//   Order pulses are mutually exclusive. Never more than one outstanding order.
// TESTING
//   1 Release reset, STARTUP_CYCLES=4 -> op_ready=0 cycles 0..3, =1 from cycle 4; busy falls with it.
//   2 op_code=2 transfer at edge N -> only order_mul=1 in cycle N+1.
//     Model answers at N+63 -> done=1 at N+64, op_count 0->1, op_ready=1 at N+64.
//   3 TIMEOUT_CYCLES=8, op_code=0, no answer -> timeout_err=1 exactly once, 8 cycles after WAIT entry; no done; op_count unchanged.
//   4 In WAIT, assert clear_a_from_pu together with au_answer -> no done, no spurious_err, INIT for 4 cycles, then op_ready=1.
//   5 op_code=6 -> illegal_err=1 one cycle after transfer, no order_* pulse, op_ready back to 1 next cycle.
//   6 au_answer while IDLE -> spurious_err pulse.
//     Preload 0xFFFF completions then one more -> op_count=0.

Source files
------------

// File: rtl/arith_order_issuer_if.sv
// ---------------------------------------------------------------------------
// arith_order_issuer_if
//   Bundles the op-sequencer handshake, the arith_ctrl order/answer lines and
//   the status/error outputs of arith_order_issuer.
//
//   master : the issuer itself (accepts opcodes, drives orders and status)
//   slave  : everything around it (op sequencer, arith_ctrl, error sink)
//
//   op_valid/op_code/op_ready   opcode handshake from the op sequencer
//   clear_a_from_pu             abort pulse
//   au_answer                   completion pulse from arith_ctrl
//   order_add..order_and        one-cycle order pulses to arith_ctrl
//   done/busy                   completion pulse / not-idle level
//   timeout_err/illegal_err/
//   spurious_err                one-cycle error pulses
//   op_count                    completed-operation counter (wraps)
// ---------------------------------------------------------------------------
interface arith_order_issuer_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic        op_ready;
    logic        clear_a_from_pu;
    logic        au_answer;
    logic        order_add;
    logic        order_sub;
    logic        order_mul;
    logic        order_div;
    logic        order_and;
    logic        done;
    logic        busy;
    logic        timeout_err;
    logic        illegal_err;
    logic        spurious_err;
    logic [15:0] op_count;

    modport master (
        input  op_valid, op_code, clear_a_from_pu, au_answer,
        output op_ready, order_add, order_sub, order_mul, order_div, order_and,
               done, busy, timeout_err, illegal_err, spurious_err, op_count
    );

    modport slave (
        output op_valid, op_code, clear_a_from_pu, au_answer,
        input  op_ready, order_add, order_sub, order_mul, order_div, order_and,
               done, busy, timeout_err, illegal_err, spurious_err, op_count
    );
endinterface

// File: rtl/arith_order_issuer.sv
// ---------------------------------------------------------------------------
// arith_order_issuer
//   Initiator side of the order/answer handshake with arith_ctrl. Takes one
//   decoded opcode at a time, fires exactly one order pulse, waits for the
//   au_answer pulse and reports completion. Flags timeouts, illegal opcodes
//   and answers that arrive outside the wait window.
//
//   Ports:
//     clk    clock
//     reset  asynchronous, active-high reset
//     bus    arith_order_issuer_if.master (handshake, orders, status, errors)
//
//   Parameters:
//     STARTUP_CYCLES  settle time after reset/abort before op_ready may rise
//     TIMEOUT_CYCLES  WAIT cycles without answer before timeout_err (2..2**CNT_W-1)
//     CNT_W           width of the shared startup/wait counter
//     OP_COUNT_INIT   reset value of op_count (0 in normal use; a preload
//                     lets the wrap-around be reached without 64k operations)
//
//   Every output is a flop. Pulses are computed from the next-state logic and
//   registered, so a pulse appears in the cycle the FSM enters the state that
//   owns it (order in ISSUE, done in DONE, errors one cycle after the cause).
// ---------------------------------------------------------------------------
module arith_order_issuer #(
    parameter int          STARTUP_CYCLES = 4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 8,
    parameter logic [15:0] OP_COUNT_INIT  = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    arith_order_issuer_if.master  bus
);

    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // order vector bit index == opcode: add, sub, mul, div, and
    localparam int N_ORD = 5;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         opc_q, opc_d;
    logic [N_ORD-1:0]   order_q, order_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tout_q, tout_d;
    logic               ill_q, ill_d;
    logic               spur_q, spur_d;
    logic [15:0]        cnt_ops_q, cnt_ops_d;

    logic               xfer;

    // op_ready is itself a flop, so the transfer condition sees exactly what
    // the sequencer sees.
    assign xfer = bus.op_valid && rdy_q;

    // -----------------------------------------------------------------------
    // Next-state and output pulse logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opc_d     = opc_q;
        order_d   = '0;
        done_d    = 1'b0;
        tout_d    = 1'b0;
        ill_d     = 1'b0;
        spur_d    = 1'b0;
        cnt_ops_d = cnt_ops_q;

        unique case (state_q)
            S_INIT: begin
                if (cnt_q == STARTUP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // DONE accepts a new opcode exactly like IDLE; without a
            // transfer it simply falls back to IDLE.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (xfer) begin
                    opc_d = bus.op_code;
                    case (bus.op_code)
                        3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
                            state_d = S_ISSUE;
                            order_d = N_ORD'(1) << bus.op_code;
                        end
                        default: ill_d = 1'b1;
                    endcase
                end
            end

            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end

            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // an answer in the limit cycle still counts as completion
                if (bus.au_answer) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    cnt_ops_d = cnt_ops_q + 16'd1;
                    cnt_d     = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_IDLE;
                    tout_d  = 1'b1;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase

        // An answer is only expected while waiting; anywhere else it is
        // reported but does not disturb the FSM.
        if (bus.au_answer && (state_q != S_WAIT))
            spur_d = 1'b1;

        // Abort outranks everything: drop any pulse that was about to be
        // registered (including an order due next cycle) and restart the
        // settle period. The completion count survives.
        if (bus.clear_a_from_pu) begin
            state_d   = S_INIT;
            cnt_d     = '0;
            order_d   = '0;
            done_d    = 1'b0;
            tout_d    = 1'b0;
            ill_d     = 1'b0;
            spur_d    = 1'b0;
            cnt_ops_d = cnt_ops_q;
        end

        // op_ready is low for the cycle that reports an illegal opcode even
        // though the FSM remains in IDLE.
        rdy_d  = ((state_d == S_IDLE) || (state_d == S_DONE)) && !ill_d;
        busy_d = (state_d != S_IDLE);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            opc_q     <= '0;
            order_q   <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            tout_q    <= 1'b0;
            ill_q     <= 1'b0;
            spur_q    <= 1'b0;
            cnt_ops_q <= OP_COUNT_INIT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opc_q     <= opc_d;
            order_q   <= order_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tout_q    <= tout_d;
            ill_q     <= ill_d;
            spur_q    <= spur_d;
            cnt_ops_q <= cnt_ops_d;
        end
    end

    assign bus.op_ready     = rdy_q;
    assign bus.order_add    = order_q[0];
    assign bus.order_sub    = order_q[1];
    assign bus.order_mul    = order_q[2];
    assign bus.order_div    = order_q[3];
    assign bus.order_and    = order_q[4];
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
    assign bus.timeout_err  = tout_q;
    assign bus.illegal_err  = ill_q;
    assign bus.spurious_err = spur_q;
    assign bus.op_count     = cnt_ops_q;

endmodule

// File: tb/tb_arith_order_issuer.sv
// ---------------------------------------------------------------------------
// tb_arith_order_issuer
//   Two issuers share clock and reset: dut_a with the default timeout, dut_b
//   with an 8-cycle timeout and op_count preloaded to 0xFFFF for the wrap.
//   Stimulus pushes every expected pulse (dut, kind, cycle, op_count) into a
//   scoreboard queue; a negedge monitor pops and compares each pulse the
//   DUTs emit, and flags pulses that never showed up. Level outputs
//   (op_ready, busy, op_count) are checked directly by the stimulus.
//   Pulse kinds: 0..4 order_add..order_and, 5 done, 6 timeout, 7 illegal,
//   8 spurious.
// ---------------------------------------------------------------------------
module tb_arith_order_issuer;

    typedef struct {
        int          dut;
        int          kind;
        int          cyc;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    bit   fin;
    exp_t sb[$];

    arith_order_issuer_if ifa ();
    arith_order_issuer_if ifb ();

    arith_order_issuer #(
        .STARTUP_CYCLES (4),
        .TIMEOUT_CYCLES (255),
        .CNT_W          (8),
        .OP_COUNT_INIT  (16'h0000)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    arith_order_issuer #(
        .STARTUP_CYCLES (4),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (8),
        .OP_COUNT_INIT  (16'hFFFF)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle k = the cycle after the k-th rising edge following reset release
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    function automatic logic [8:0] pulses(input int d);
        if (d == 0)
            return {ifa.spurious_err, ifa.illegal_err, ifa.timeout_err, ifa.done,
                    ifa.order_and, ifa.order_div, ifa.order_mul, ifa.order_sub, ifa.order_add};
        return {ifb.spurious_err, ifb.illegal_err, ifb.timeout_err, ifb.done,
                ifb.order_and, ifb.order_div, ifb.order_mul, ifb.order_sub, ifb.order_add};
    endfunction

    always @(negedge clk) begin
        if (!reset && !fin) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse dut=%0d kind=%0d: required at cycle %0d, not seen",
                         sb[0].dut, sb[0].kind, sb[0].cyc);
                void'(sb.pop_front());
            end
            for (int d = 0; d < 2; d++) begin
                logic [8:0]  p;
                logic [15:0] oc;
                p  = pulses(d);
                oc = (d == 0) ? ifa.op_count : ifb.op_count;
                for (int k = 0; k < 9; k++) begin
                    if (p[k]) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_pulse dut=%0d kind=%0d cycle=%0d: nothing expected",
                                     d, k, cyc);
                        end else if (sb[0].dut != d || sb[0].kind != k || sb[0].cyc != cyc ||
                                     ((k == 5 || k == 6) && sb[0].cnt != oc)) begin
                            errors++;
                            $display("FAIL pulse dut=%0d kind=%0d cycle=%0d op_count=%h: required dut=%0d kind=%0d cycle=%0d op_count=%h",
                                     d, k, cyc, oc, sb[0].dut, sb[0].kind, sb[0].cyc, sb[0].cnt);
                            if (sb[0].cyc == cyc) void'(sb.pop_front());
                        end else begin
                            void'(sb.pop_front());
                        end
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (all called at a negedge, return at a negedge)
    // -----------------------------------------------------------------------
    task automatic push(input int d, input int k, input int c, input logic [15:0] n);
        exp_t e;
        e.dut = d; e.kind = k; e.cyc = c; e.cnt = n;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d: got %h, required %h", name, cyc, act, req);
        end
    endtask

    task automatic drive_op(input int d, input logic v, input logic [2:0] c);
        if (d == 0) begin ifa.op_valid = v; ifa.op_code = c; end
        else        begin ifb.op_valid = v; ifb.op_code = c; end
    endtask

    task automatic drive_ans(input int d, input logic a);
        if (d == 0) ifa.au_answer = a;
        else        ifb.au_answer = a;
    endtask

    task automatic issue(input int d, input int code);
        int n0;
        n0 = cyc;
        drive_op(d, 1'b1, 3'(code));
        if (code <= 4) push(d, code, n0 + 1, 16'h0);
        else           push(d, 7, n0 + 1, 16'h0);
        @(negedge clk);
        drive_op(d, 1'b0, 3'd0);
    endtask

    task automatic answer(input int d, input bit is_done, input logic [15:0] n);
        int n0;
        n0 = cyc;
        drive_ans(d, 1'b1);
        push(d, is_done ? 5 : 8, n0 + 1, n);
        @(negedge clk);
        drive_ans(d, 1'b0);
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        int n;
        checks = 0; errors = 0; fin = 1'b0;
        reset = 1'b1;
        ifa.op_valid = 0; ifa.op_code = 0; ifa.clear_a_from_pu = 0; ifa.au_answer = 0;
        ifb.op_valid = 0; ifb.op_code = 0; ifb.clear_a_from_pu = 0; ifb.au_answer = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // startup: op_ready low cycles 0..3, high from 4; busy mirrors it
        chk("rst_count_a", 32'(ifa.op_count), 32'h0000);
        chk("rst_count_b", 32'(ifb.op_count), 32'hFFFF);
        for (int c = 0; c < 5; c++) begin
            chk("startup_ready", 32'(ifa.op_ready), 32'(c == 4));
            chk("startup_busy",  32'(ifa.busy),     32'(c != 4));
            if (c < 4) @(negedge clk);
        end

        // mul, answered 63 cycles after the transfer
        n = cyc;
        issue(0, 2);
        to_cyc(n + 63);
        answer(0, 1'b1, 16'd1);
        chk("done_ready", 32'(ifa.op_ready), 32'd1);

        // sub answered at once, then div accepted in the DONE cycle
        @(negedge clk);
        issue(0, 1);
        @(negedge clk);
        answer(0, 1'b1, 16'd2);
        chk("b2b_ready", 32'(ifa.op_ready), 32'd1);
        issue(0, 3);
        @(negedge clk);
        answer(0, 1'b1, 16'd3);

        // illegal opcode: error pulse, op_ready low one cycle
        @(negedge clk);
        issue(0, 6);
        chk("illegal_ready_low", 32'(ifa.op_ready), 32'd0);
        @(negedge clk);
        chk("illegal_ready_back", 32'(ifa.op_ready), 32'd1);

        // stray answer while idle
        answer(0, 1'b0, 16'd0);

        // abort in WAIT together with an answer: silent, 4 cycles of INIT
        n = cyc;
        issue(0, 0);
        to_cyc(n + 11);
        ifa.clear_a_from_pu = 1'b1;
        ifa.au_answer       = 1'b1;
        @(negedge clk);
        ifa.clear_a_from_pu = 1'b0;
        ifa.au_answer       = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("abort_ready", 32'(ifa.op_ready), 32'(c == 4));
            chk("abort_busy",  32'(ifa.busy),     32'(c != 4));
            if (c < 4) @(negedge clk);
        end
        chk("abort_count_kept", 32'(ifa.op_count), 32'd3);
        issue(0, 4);
        @(negedge clk);
        answer(0, 1'b1, 16'd4);

        // dut_b: timeout 8 cycles after WAIT entry, count untouched
        @(negedge clk);
        n = cyc;
        issue(1, 0);
        push(1, 6, n + 10, 16'hFFFF);
        to_cyc(n + 10);
        chk("timeout_ready", 32'(ifb.op_ready), 32'd1);
        @(negedge clk);

        // one completion wraps op_count 0xFFFF -> 0
        issue(1, 4);
        @(negedge clk);
        answer(1, 1'b1, 16'h0000);
        chk("wrap_count", 32'(ifb.op_count), 32'h0000);

        // answer in the last allowed WAIT cycle beats the timeout
        @(negedge clk);
        n = cyc;
        issue(1, 1);
        to_cyc(n + 9);
        answer(1, 1'b1, 16'h0001);

        // illegal opcode and stray answer in the same cycle
        @(negedge clk);
        n = cyc;
        drive_op(1, 1'b1, 3'd7);
        drive_ans(1, 1'b1);
        push(1, 7, n + 1, 16'h0);
        push(1, 8, n + 1, 16'h0);
        @(negedge clk);
        drive_op(1, 1'b0, 3'd0);
        drive_ans(1, 1'b0);
        chk("both_err_ready", 32'(ifb.op_ready), 32'd0);

        repeat (6) @(negedge clk);
        fin = 1'b1;
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse dut=%0d kind=%0d: required at cycle %0d, not seen",
                     sb[0].dut, sb[0].kind, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
